// File: rtl/lbus_arbiter_if.sv
// Bundles the requester-side and downstream-side lbus signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters plus the AXI bridge.
interface lbus_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int AddrW = 32,
    parameter int DataW = 64,
    parameter int IdW   = 3
);
    logic [NREQ-1:0]           s_req;
    logic [NREQ*AddrW-1:0]     s_addr;
    logic [NREQ*DataW-1:0]     s_wdata;
    logic [NREQ*(DataW/8)-1:0] s_strb;
    logic [NREQ-1:0]           s_busyo;
    logic [NREQ-1:0]           s_readyo;
    logic [DataW-1:0]          s_rdatao;
    logic                      m_reqo;
    logic [IdW-1:0]            m_ido;
    logic [DataW/8-1:0]        m_strbo;
    logic [AddrW-1:0]          m_addro;
    logic [DataW-1:0]          m_wdatao;
    logic                      m_busy;
    logic                      m_ready;
    logic [IdW-1:0]            m_id;
    logic [DataW-1:0]          m_rdata;
    logic                      stray_o;

    modport master (
        output s_req, s_addr, s_wdata, s_strb, m_busy, m_ready, m_id, m_rdata,
        input  s_busyo, s_readyo, s_rdatao, m_reqo, m_ido, m_strbo, m_addro, m_wdatao, stray_o
    );

    modport slave (
        input  s_req, s_addr, s_wdata, s_strb, m_busy, m_ready, m_id, m_rdata,
        output s_busyo, s_readyo, s_rdatao, m_reqo, m_ido, m_strbo, m_addro, m_wdatao, stray_o
    );
endinterface

// File: rtl/lbus_arbiter.sv
// Round-robin arbiter sharing one lbus DDR port among NREQ requesters, one transaction outstanding.
// Accept -> m_reqo 1 cycle; m_ready -> s_readyo 1 cycle; m_busy holds the issued command stable.
module lbus_arbiter #(
    parameter int NREQ  = 4,
    parameter int AddrW = 32,
    parameter int DataW = 64,
    parameter int IdW   = 3
) (
    input  logic         i_clk,
    input  logic         i_reset,
    lbus_arbiter_if.slave bus
);
    localparam int StrbW = DataW / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IdW-1:0]   r_rr_ptr;
    logic [IdW-1:0]   r_grant;
    logic [AddrW-1:0] r_addr;
    logic [DataW-1:0] r_wdata;
    logic [StrbW-1:0] r_strb;
    logic [NREQ-1:0]  r_readyo;
    logic [DataW-1:0] r_rdata;
    logic             r_stray;

    logic [NREQ-1:0]  w_req_rot;
    logic             w_found;
    logic [IdW-1:0]   w_winner;
    logic [IdW:0]     w_sum;
    logic [IdW:0]     w_ptr_sum;
    logic [IdW-1:0]   w_ptr_nxt;
    logic [AddrW-1:0] w_addr_sel;
    logic [DataW-1:0] w_wdata_sel;
    logic [StrbW-1:0] w_strb_sel;
    logic [NREQ-1:0]  w_onehot_busy;
    logic [NREQ-1:0]  w_readyo_nxt;
    logic             w_grant_now;
    logic             w_resp_ok;

    // Rotate requests so bit 0 is the requester at rr_ptr; first set bit wins.
    always_comb begin
        w_req_rot     = (bus.s_req >> r_rr_ptr) | (bus.s_req << (NREQ - int'(r_rr_ptr)));
        w_found       = 1'b0;
        w_winner      = '0;
        w_sum         = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && w_req_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_rr_ptr} + (IdW+1)'(k);
                if (w_sum >= (IdW+1)'(NREQ)) begin
                    w_sum = w_sum - (IdW+1)'(NREQ);
                end
                w_winner = w_sum[IdW-1:0];
            end
        end
        w_ptr_sum = {1'b0, w_winner} + {{IdW{1'b0}}, 1'b1};
        w_ptr_nxt = (w_ptr_sum == (IdW+1)'(NREQ)) ? '0 : w_ptr_sum[IdW-1:0];
    end

    always_comb begin
        w_addr_sel    = '0;
        w_wdata_sel   = '0;
        w_strb_sel    = '0;
        w_onehot_busy = '1;
        w_readyo_nxt  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_winner == IdW'(k)) begin
                w_addr_sel  = bus.s_addr[k*AddrW +: AddrW];
                w_wdata_sel = bus.s_wdata[k*DataW +: DataW];
                w_strb_sel  = bus.s_strb[k*StrbW +: StrbW];
            end
            if (w_found && w_winner == IdW'(k)) begin
                w_onehot_busy[k] = 1'b0;
            end
            if (w_resp_ok && r_grant == IdW'(k)) begin
                w_readyo_nxt[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_now  = 1'b0;
        w_resp_ok    = bus.m_ready && (r_state == WAIT) && (bus.m_id == r_grant);
        bus.s_busyo  = '1;
        bus.m_reqo   = 1'b0;
        bus.m_ido    = '0;
        bus.m_addro  = '0;
        bus.m_wdatao = '0;
        bus.m_strbo  = '0;
        case (r_state)
            IDLE: begin
                bus.s_busyo = w_onehot_busy;
                if (w_found) begin
                    w_grant_now = 1'b1;
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                bus.m_reqo = 1'b1;
                if (!bus.m_busy) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (w_resp_ok) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (!i_reset) begin
            bus.m_ido    = r_grant;
            bus.m_addro  = r_addr;
            bus.m_wdatao = r_wdata;
            bus.m_strbo  = r_strb;
        end else begin
            // Reset overrides the registered view immediately, not one cycle later.
            bus.s_busyo = '1;
            bus.m_reqo  = 1'b0;
            w_grant_now = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_rr_ptr <= '0;
            r_grant  <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_strb   <= '0;
            r_readyo <= '0;
            r_rdata  <= '0;
            r_stray  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_readyo <= w_readyo_nxt;
            r_stray  <= bus.m_ready && !w_resp_ok;
            if (w_grant_now) begin
                r_grant  <= w_winner;
                r_rr_ptr <= w_ptr_nxt;
                r_addr   <= w_addr_sel;
                r_wdata  <= w_wdata_sel;
                r_strb   <= w_strb_sel;
            end
            if (w_resp_ok) begin
                r_rdata <= bus.m_rdata;
            end
        end
    end

    assign bus.s_readyo = r_readyo;
    assign bus.s_rdatao = r_rdata;
    assign bus.stray_o  = r_stray;

endmodule

// File: tb/tb_lbus_arbiter.sv
// Self-checking bench for lbus_arbiter: randomized traffic against a round-robin reference model.
module tb_lbus_arbiter;
    localparam int NREQ  = 4;
    localparam int AddrW = 32;
    localparam int DataW = 64;
    localparam int IdW   = 3;
    localparam int StrbW = DataW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   model_ptr = 0;

    logic [AddrW-1:0] req_addr [NREQ];
    logic [DataW-1:0] req_wdata[NREQ];
    logic [StrbW-1:0] req_strb [NREQ];

    lbus_arbiter_if #(.NREQ(NREQ), .AddrW(AddrW), .DataW(DataW), .IdW(IdW)) bif ();

    lbus_arbiter #(.NREQ(NREQ), .AddrW(AddrW), .DataW(DataW), .IdW(IdW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_up(input logic [NREQ-1:0] req);
        for (int i = 0; i < NREQ; i++) begin
            bif.s_addr[i*AddrW +: AddrW]  = req_addr[i];
            bif.s_wdata[i*DataW +: DataW] = req_wdata[i];
            bif.s_strb[i*StrbW +: StrbW]  = req_strb[i];
        end
        bif.s_req = req;
    endtask

    task automatic randomize_slots();
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i]  = $urandom;
            req_wdata[i] = {$urandom, $urandom};
            req_strb[i]  = 8'($urandom);
        end
    endtask

    // Reference: first requesting index found walking upward from ptr, wrapping.
    function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic test_reset();
        bif.s_req = '0; bif.s_addr = '0; bif.s_wdata = '0; bif.s_strb = '0;
        bif.m_busy = 1'b0; bif.m_ready = 1'b0; bif.m_id = '0; bif.m_rdata = '0;
        rst = 1'b1;
        tick(); tick();
        bif.s_req = '1;
        #1;
        n_tests++; if (bif.s_busyo !== 4'hF) begin n_fail++; $display("FAIL reset_busy: got %b want 1111", bif.s_busyo); end
        tick();
        n_tests++; if (bif.m_reqo !== 1'b0) begin n_fail++; $display("FAIL reset_mreq: got %b want 0", bif.m_reqo); end
        n_tests++; if (bif.s_readyo !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", bif.s_readyo); end
        n_tests++; if (bif.s_rdatao !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bif.s_rdatao); end
        n_tests++; if (bif.stray_o !== 1'b0) begin n_fail++; $display("FAIL reset_stray: got %b want 0", bif.stray_o); end
        n_tests++; if ({bif.m_ido, bif.m_addro, bif.m_wdatao, bif.m_strbo} !== '0) begin n_fail++; $display("FAIL reset_mcmd: got %h want 0", {bif.m_ido, bif.m_addro}); end
        bif.s_req = '0;
        rst = 1'b0;
        model_ptr = 0;
        tick();
    endtask

    // First 8 transactions: all requesters held high; then random patterns, delays and backpressure.
    task automatic test_round_robin();
        logic [NREQ-1:0]  pat;
        logic [AddrW-1:0] e_addr;
        logic [DataW-1:0] e_wdata, rd;
        logic [StrbW-1:0] e_strb;
        int exp, nbusy, dly;
        bit fair;
        for (int t = 0; t < 20; t++) begin
            fair  = (t < 8);
            pat   = fair ? 4'hF : 4'($urandom_range(1, 15));
            nbusy = fair ? 0 : int'($urandom_range(0, 3));
            dly   = fair ? 0 : int'($urandom_range(0, 3));
            exp   = rr_pick(pat, model_ptr);
            randomize_slots();
            e_addr = req_addr[exp]; e_wdata = req_wdata[exp]; e_strb = req_strb[exp];
            drive_up(pat);
            #1;
            n_tests++; if (bif.s_busyo !== ~(4'b1 << exp)) begin n_fail++; $display("FAIL rr_busy t=%0d: got %b want %b", t, bif.s_busyo, ~(4'b1 << exp)); end
            tick();
            randomize_slots();
            drive_up(fair ? pat : 4'h0);
            n_tests++; if (fair && bif.m_ido !== IdW'(t % NREQ)) begin n_fail++; $display("FAIL rr_fair_order t=%0d: got %0d want %0d", t, bif.m_ido, t % NREQ); end
            n_tests++; if (bif.m_reqo !== 1'b1 || bif.m_ido !== IdW'(exp)) begin n_fail++; $display("FAIL rr_issue t=%0d: got req=%b id=%0d want req=1 id=%0d", t, bif.m_reqo, bif.m_ido, exp); end
            n_tests++; if (bif.m_addro !== e_addr || bif.m_wdatao !== e_wdata || bif.m_strbo !== e_strb) begin n_fail++; $display("FAIL rr_cmd t=%0d: got %h/%h/%h want %h/%h/%h", t, bif.m_addro, bif.m_wdatao, bif.m_strbo, e_addr, e_wdata, e_strb); end
            bif.m_busy = 1'b1;
            for (int b = 0; b < nbusy; b++) begin
                tick();
                n_tests++; if (bif.m_reqo !== 1'b1 || bif.m_addro !== e_addr || bif.s_busyo !== 4'hF) begin n_fail++; $display("FAIL rr_hold t=%0d: got req=%b addr=%h busy=%b", t, bif.m_reqo, bif.m_addro, bif.s_busyo); end
            end
            bif.m_busy = 1'b0;
            tick();
            n_tests++; if (bif.m_reqo !== 1'b0) begin n_fail++; $display("FAIL rr_mreq_drop t=%0d: got %b want 0", t, bif.m_reqo); end
            repeat (dly) tick();
            rd = {$urandom, $urandom};
            bif.m_ready = 1'b1; bif.m_id = IdW'(exp); bif.m_rdata = rd;
            tick();
            bif.m_ready = 1'b0;
            n_tests++; if (bif.s_readyo !== (4'b1 << exp) || bif.s_rdatao !== rd) begin n_fail++; $display("FAIL rr_resp t=%0d: got %b/%h want %b/%h", t, bif.s_readyo, bif.s_rdatao, 4'b1 << exp, rd); end
            n_tests++; if (bif.stray_o !== 1'b0) begin n_fail++; $display("FAIL rr_stray t=%0d: got %b want 0", t, bif.stray_o); end
            model_ptr = (exp + 1) % NREQ;
        end
        drive_up(4'h0);
        tick();
    endtask

    task automatic test_single_read();
        randomize_slots();
        req_addr[1] = 32'h1000_0000; req_strb[1] = 8'h00;
        drive_up(4'b0010);
        #1;
        n_tests++; if (bif.s_busyo !== 4'b1101) begin n_fail++; $display("FAIL single_busy: got %b want 1101", bif.s_busyo); end
        tick();
        drive_up(4'b0000);
        n_tests++; if (bif.m_reqo !== 1'b1 || bif.m_ido !== 3'd1 || bif.m_addro !== 32'h1000_0000 || bif.m_strbo !== 8'h00) begin n_fail++; $display("FAIL single_issue: got req=%b id=%0d addr=%h strb=%h", bif.m_reqo, bif.m_ido, bif.m_addro, bif.m_strbo); end
        tick();
        tick(); tick();
        n_tests++; if (bif.s_readyo !== 4'h0) begin n_fail++; $display("FAIL single_early_ready: got %b want 0000", bif.s_readyo); end
        bif.m_ready = 1'b1; bif.m_id = 3'd1; bif.m_rdata = 64'hDEADBEEF_CAFEF00D;
        tick();
        bif.m_ready = 1'b0; bif.m_rdata = '0;
        n_tests++; if (bif.s_readyo !== 4'b0010 || bif.s_rdatao !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL single_resp: got %b/%h want 0010/deadbeefcafef00d", bif.s_readyo, bif.s_rdatao); end
        tick();
        n_tests++; if (bif.s_readyo !== 4'h0 || bif.s_rdatao !== 64'hDEADBEEF_CAFEF00D) begin n_fail++; $display("FAIL single_hold: got %b/%h want 0000/deadbeefcafef00d", bif.s_readyo, bif.s_rdatao); end
        model_ptr = 2;
    endtask

    task automatic test_backpressure();
        randomize_slots();
        req_strb[3] = 8'hFF; req_wdata[3] = 64'h0123_4567_89AB_CDEF; req_addr[3] = 32'h2000_0040;
        drive_up(4'b1000);
        bif.m_busy = 1'b1;
        tick();
        drive_up(4'b0000);
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (bif.m_reqo !== 1'b1 || bif.m_ido !== 3'd3 || bif.m_addro !== 32'h2000_0040 || bif.m_wdatao !== 64'h0123_4567_89AB_CDEF || bif.m_strbo !== 8'hFF || bif.s_busyo !== 4'hF) begin
                n_fail++; $display("FAIL bp_hold c=%0d: got req=%b id=%0d addr=%h wd=%h strb=%h busy=%b", c, bif.m_reqo, bif.m_ido, bif.m_addro, bif.m_wdatao, bif.m_strbo, bif.s_busyo);
            end
            drive_up(4'b0111);
            tick();
        end
        bif.m_busy = 1'b0;
        drive_up(4'b0000);
        tick();
        n_tests++; if (bif.m_reqo !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b want 0", bif.m_reqo); end
        bif.m_ready = 1'b1; bif.m_id = 3'd3; bif.m_rdata = 64'h0;
        tick();
        bif.m_ready = 1'b0;
        n_tests++; if (bif.s_readyo !== 4'b1000) begin n_fail++; $display("FAIL bp_resp: got %b want 1000", bif.s_readyo); end
        model_ptr = 0;
    endtask

    task automatic test_stray();
        bif.m_ready = 1'b1; bif.m_id = 3'd0; bif.m_rdata = 64'h1111;
        tick();
        bif.m_ready = 1'b0;
        n_tests++; if (bif.stray_o !== 1'b1 || bif.s_readyo !== 4'h0) begin n_fail++; $display("FAIL stray_idle: got stray=%b ready=%b want 1/0000", bif.stray_o, bif.s_readyo); end
        randomize_slots();
        drive_up(4'b0010);
        tick();
        drive_up(4'b0000);
        n_tests++; if (bif.stray_o !== 1'b0 || bif.m_ido !== 3'd1) begin n_fail++; $display("FAIL stray_grant: got stray=%b id=%0d want 0/1", bif.stray_o, bif.m_ido); end
        tick();
        bif.m_ready = 1'b1; bif.m_id = 3'd2; bif.m_rdata = 64'h2222;
        tick();
        n_tests++; if (bif.stray_o !== 1'b1 || bif.s_readyo !== 4'h0) begin n_fail++; $display("FAIL stray_wrong_id: got stray=%b ready=%b want 1/0000", bif.stray_o, bif.s_readyo); end
        bif.m_id = 3'd1; bif.m_rdata = 64'h5A5A_0000_A5A5_FFFF;
        tick();
        bif.m_ready = 1'b0;
        n_tests++; if (bif.stray_o !== 1'b0 || bif.s_readyo !== 4'b0010 || bif.s_rdatao !== 64'h5A5A_0000_A5A5_FFFF) begin n_fail++; $display("FAIL stray_recover: got stray=%b ready=%b rd=%h", bif.stray_o, bif.s_readyo, bif.s_rdatao); end
        model_ptr = 2;
    endtask

    task automatic test_reset_mid();
        int exp;
        randomize_slots();
        drive_up(4'b0100);
        tick();
        drive_up(4'b0000);
        n_tests++; if (bif.m_ido !== 3'd2) begin n_fail++; $display("FAIL rmid_grant: got %0d want 2", bif.m_ido); end
        tick();
        tick();
        rst = 1'b1;
        drive_up(4'b1111);
        #1;
        n_tests++; if (bif.s_busyo !== 4'hF || bif.m_reqo !== 1'b0) begin n_fail++; $display("FAIL rmid_comb: got busy=%b req=%b want 1111/0", bif.s_busyo, bif.m_reqo); end
        tick();
        n_tests++; if (bif.s_rdatao !== 64'h0 || bif.s_readyo !== 4'h0 || bif.stray_o !== 1'b0 || bif.m_addro !== 32'h0 || bif.s_busyo !== 4'hF) begin n_fail++; $display("FAIL rmid_outs: got rd=%h ready=%b stray=%b addr=%h busy=%b", bif.s_rdatao, bif.s_readyo, bif.stray_o, bif.m_addro, bif.s_busyo); end
        rst = 1'b0;
        drive_up(4'b0000);
        bif.m_ready = 1'b1; bif.m_id = 3'd2; bif.m_rdata = 64'h3333;
        tick();
        bif.m_ready = 1'b0;
        n_tests++; if (bif.stray_o !== 1'b1 || bif.s_readyo !== 4'h0) begin n_fail++; $display("FAIL rmid_late_resp: got stray=%b ready=%b want 1/0000", bif.stray_o, bif.s_readyo); end
        model_ptr = 0;
        exp = rr_pick(4'b1111, model_ptr);
        drive_up(4'b1111);
        #1;
        n_tests++; if (bif.s_busyo !== ~(4'b1 << exp)) begin n_fail++; $display("FAIL rmid_next_busy: got %b want %b", bif.s_busyo, ~(4'b1 << exp)); end
        tick();
        drive_up(4'b0000);
        n_tests++; if (bif.m_ido !== IdW'(exp) || bif.m_reqo !== 1'b1) begin n_fail++; $display("FAIL rmid_next_grant: got id=%0d req=%b want %0d/1", bif.m_ido, bif.m_reqo, exp); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_single_read();
        test_backpressure();
        test_stray();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
